// File: rtl/usrt_pkg.sv
// Shared constants, state encoding and helpers for the USRT transfer controller.
// Frame layout on the wire, LSB first: start, 8 data bits, parity, stop.
package usrt_pkg;
  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT = 1'b0;
  localparam logic LINE_IDLE = 1'b0;

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  localparam int ST_PAR = 0;
  localparam int ST_FRM = 1;
  localparam int ST_TMO = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_FRAME = 3'd1,
    ST_RX_HUNT  = 3'd2,
    ST_RX_FRAME = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/usrt_xfer_ctrl_if.sv
// APB slave signals, serial pins and FSM debug state of the USRT transfer controller.
// Handshake: an access starts when pSelect&pEnable are seen in IDLE; pReady pulses one cycle to end it.
interface usrt_xfer_ctrl_if #(
  parameter int ADDR_W = 32
);
  import usrt_pkg::*;

  logic              pSelect;
  logic              pEnable;
  logic              pWrite;
  logic [ADDR_W-1:0] pAddress;
  logic [7:0]        pWData;
  logic [7:0]        pRData;
  logic              pReady;
  logic              pSlvErr;
  logic              Tx;
  logic              Rx;
  logic              uClk;
  logic              dir;
  state_e            dbg_state;

  modport slave (
    input  pSelect, pEnable, pWrite, pAddress, pWData, Tx,
    output pRData, pReady, pSlvErr, Rx, uClk, dir, dbg_state
  );

  modport master (
    output pSelect, pEnable, pWrite, pAddress, pWData, Tx,
    input  pRData, pReady, pSlvErr, Rx, uClk, dir, dbg_state
  );
endinterface

// File: rtl/usrt_baud_tick.sv
// Bit-period divider: counts 0..BAUD_DIV-1 and ticks on the last count.
// While clr is high the count is held at zero and no tick is produced.
module usrt_baud_tick #(
  parameter int BAUD_DIV = 80
) (
  input  logic pClk,
  input  logic pReset,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign tick   = at_end & ~clr;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || at_end) cnt_d = '0;
  end

  always_ff @(posedge pClk) begin
    if (pReset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usrt_xfer_ctrl.sv
// APB-side transfer controller: one 11-bit frame per DATA access, out on Rx for writes,
// hunted and captured from Tx for reads; pReady is held off until the frame completes.
module usrt_xfer_ctrl
  import usrt_pkg::*;
#(
  parameter int BAUD_DIV   = 80,
  parameter int RX_TIMEOUT = 64,
  parameter int ADDR_W     = 32
) (
  input logic pClk,
  input logic pReset,
  usrt_xfer_ctrl_if.slave bus
);
  localparam int TMO_W = $clog2(RX_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [10:0]      tx_sh_q, tx_sh_d;
  logic [9:0]       rx_sh_q, rx_sh_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [2:0]       status_q, status_d, status_set;
  logic             status_clr;
  logic [7:0]       resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_status_q, resp_status_d;
  logic             wr_q, wr_d;
  logic             tick, div_clr, access;
  logic [3:0]       addr_lo;
  logic [9:0]       rx_word;
  logic             par_bad, stop_bad;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^bus.pAddress[ADDR_W-1:4];
  assign access  = bus.pSelect & bus.pEnable;
  assign addr_lo = bus.pAddress[3:0];
  assign rx_word = {bus.Tx, rx_sh_q[9:1]};
  assign par_bad  = (parity8(rx_word[7:0]) != rx_word[8]);
  assign stop_bad = (rx_word[9] != STOP_BIT);
  assign div_clr = (state_q == ST_IDLE) || (state_q == ST_RESP);

  usrt_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .pClk  (pClk),
    .pReset(pReset),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d       = state_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    hunt_cnt_d    = hunt_cnt_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    resp_status_d = resp_status_q;
    wr_d          = wr_q;
    status_set    = '0;
    status_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          wr_d          = bus.pWrite;
          bit_cnt_d     = '0;
          hunt_cnt_d    = '0;
          resp_data_d   = '0;
          resp_err_d    = 1'b0;
          resp_status_d = 1'b0;
          if (addr_lo == ADDR_DATA && bus.pWrite) begin
            tx_sh_d = {STOP_BIT, parity8(bus.pWData), bus.pWData, START_BIT};
            state_d = ST_TX_FRAME;
          end else if (addr_lo == ADDR_DATA) begin
            state_d = ST_RX_HUNT;
          end else if (addr_lo == ADDR_STATUS && !bus.pWrite) begin
            resp_status_d = 1'b1;
            resp_data_d   = {5'b0, status_q};
            state_d       = ST_RESP;
          end else begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_TX_FRAME: begin
        if (!bus.pSelect) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          tx_sh_d = {LINE_IDLE, tx_sh_q[10:1]};
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = ST_RESP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_RX_HUNT: begin
        if (!bus.pSelect) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (bus.Tx == START_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_RX_FRAME;
          end else if (hunt_cnt_q == TMO_W'(RX_TIMEOUT - 1)) begin
            resp_err_d         = 1'b1;
            status_set[ST_TMO] = 1'b1;
            state_d            = ST_RESP;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 1'b1;
          end
        end
      end
      ST_RX_FRAME: begin
        if (!bus.pSelect) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          rx_sh_d = rx_word;
          // The tick carrying the stop bit closes the frame; both checks may flag together.
          if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
            status_set[ST_PAR] = par_bad;
            status_set[ST_FRM] = stop_bad;
            resp_err_d         = par_bad | stop_bad;
            resp_data_d        = (par_bad | stop_bad) ? 8'h00 : rx_word[7:0];
            state_d            = ST_RESP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        status_clr = resp_status_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    status_d = (status_clr ? 3'b000 : status_q) | status_set;
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      state_q       <= ST_IDLE;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      hunt_cnt_q    <= '0;
      status_q      <= '0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      resp_status_q <= 1'b0;
      wr_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      hunt_cnt_q    <= hunt_cnt_d;
      status_q      <= status_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      resp_status_q <= resp_status_d;
      wr_q          <= wr_d;
    end
  end

  assign bus.pReady    = (state_q == ST_RESP);
  assign bus.pRData    = bus.pReady ? resp_data_q : 8'h00;
  assign bus.pSlvErr   = bus.pReady & resp_err_q;
  assign bus.Rx        = (state_q == ST_TX_FRAME) ? tx_sh_q[0] : LINE_IDLE;
  assign bus.uClk      = tick;
  assign bus.dir       = (state_q == ST_IDLE) ? 1'b1 : ~wr_q;
  assign bus.dbg_state = state_q;
endmodule
